seq_restoring_divider: RTL

- Multi-cycle unsigned integer divider. It computes quotient and remainder by restoring shift-and-subtract, one quotient bit per clock.
- It is the inverse-operation companion to the team's combinational adder/subtractor chain. Each iteration reuses a (WIDTH+1)-bit subtract.
- Sits beside the arithmetic blocks as the slow-path divide unit. It uses a start/busy/done handshake toward its requester.

---
 rtl/seq_restoring_divider.sv | 120 ++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
// Each CALC cycle produces one quotient bit from a (WIDTH+1)-bit trial subtract.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dsr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;

    logic [WIDTH-1:0] w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_last;

    // r_q starts as the dividend and fills with quotient bits as dividend bits shift out.
    always_comb begin
        w_rem_sh = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
        w_trial  = {1'b0, w_rem_sh} - {1'b0, r_dsr};
        if (w_trial[WIDTH]) begin
            w_rem_next = w_rem_sh;
            w_q_next   = {r_q[WIDTH-2:0], 1'b0};
        end else begin
            w_rem_next = w_trial[WIDTH-1:0];
            w_q_next   = {r_q[WIDTH-2:0], 1'b1};
        end
        w_last = (r_cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_rem   <= '0;
            r_dsr   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_quot  <= '0;
            r_remo  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_q   <= dividend;
                        r_dsr <= divisor;
                        r_rem <= '0;
                        r_cnt <= '0;
                        if (divisor == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_quot  <= '1;
                            r_remo  <= dividend;
                            r_dbz   <= 1'b1;
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    r_q   <= w_q_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_quot  <= w_q_next;
                        r_remo  <= w_rem_next;
                        r_dbz   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dbz;

endmodule
